// File: rtl/vector_mem_sequencer.sv
// Splits one vector load/store into DATA_W-wide beats on the memory stage's vector port,
// reassembling load beats into a full vector and stalling the pipeline while in flight.
module vector_mem_sequencer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned VEC_W  = 128,
    parameter int unsigned STRIDE = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              is_store,
    input  logic [31:0]       base_address,
    input  logic [VEC_W-1:0]  store_data,
    output logic [31:0]       mem_address,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [VEC_W-1:0]  load_data,
    output logic              busy,
    output logic              done,
    output logic              stall
);

    localparam int unsigned LANES  = VEC_W / DATA_W;
    localparam int unsigned BEAT_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [BEAT_W-1:0] LastBeat = BEAT_W'(LANES - 1);

    typedef enum logic [2:0] {StIdle, StStore, StLoad, StDrain, StDone} state_e;

    state_e              state_q;
    logic [BEAT_W-1:0]   beat_q;
    logic [VEC_W-1:0]    vec_q;
    logic [31:0]         addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                we_q;
    logic                busy_q;
    logic                done_q;
    logic [VEC_W-1:0]    load_q;

    logic [BEAT_W-1:0]   next_beat;
    logic [BEAT_W-1:0]   prev_beat;

    always_comb begin
        next_beat = beat_q + 1'b1;
        prev_beat = beat_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            beat_q  <= '0;
            vec_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            // An aborted transfer keeps the last completed load result visible.
            if (!busy_q) begin
                load_q <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_q <= is_store ? StStore : StLoad;
                        beat_q  <= '0;
                        vec_q   <= store_data;
                        addr_q  <= base_address;
                        wdata_q <= store_data[DATA_W-1:0];
                        we_q    <= is_store;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StStore: begin
                    if (beat_q == LastBeat) begin
                        state_q <= StDone;
                        we_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        beat_q  <= next_beat;
                        addr_q  <= addr_q + 32'(STRIDE);
                        wdata_q <= vec_q[next_beat*DATA_W +: DATA_W];
                    end
                end
                StLoad: begin
                    // Read data lags its address by one cycle, so each beat captures the previous lane.
                    if (beat_q != '0) begin
                        vec_q[prev_beat*DATA_W +: DATA_W] <= mem_rdata;
                    end
                    if (beat_q == LastBeat) begin
                        state_q <= StDrain;
                    end else begin
                        beat_q <= next_beat;
                        addr_q <= addr_q + 32'(STRIDE);
                    end
                end
                StDrain: begin
                    load_q  <= {mem_rdata, vec_q[VEC_W-DATA_W-1:0]};
                    state_q <= StDone;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign mem_address = addr_q;
    assign mem_we      = we_q & reset;
    assign mem_wdata   = wdata_q;
    assign load_data   = load_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign stall       = busy_q | (start & (state_q == StIdle));

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Randomized bench for vector_mem_sequencer against a transaction-level model that predicts
// each cycle's outputs from the accept cycle offset, with a read-data memory of addr^0xA5A5A5A5.
module tb_vector_mem_sequencer;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         is_store;
    logic [31:0]  base_address;
    logic [127:0] store_data;
    logic [31:0]  mem_address;
    logic         mem_we;
    logic [31:0]  mem_wdata;
    logic [31:0]  mem_rdata = 32'h0;
    logic [127:0] load_data;
    logic         busy;
    logic         done;
    logic         stall;

    always #5 clk = ~clk;

    vector_mem_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .is_store     (is_store),
        .base_address (base_address),
        .store_data   (store_data),
        .mem_address  (mem_address),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .load_data    (load_data),
        .busy         (busy),
        .done         (done),
        .stall        (stall)
    );

    // Memory stage: read data for an address appears one cycle later.
    always @(posedge clk) mem_rdata <= mem_address ^ 32'hA5A5A5A5;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    // Transaction model: offset k counts cycles since accept (1 = first beat).
    bit           m_active = 1'b0;
    bit           m_store  = 1'b0;
    bit           m_fresh  = 1'b1;
    int           m_k      = 0;
    int           accepts  = 0;
    logic [31:0]  m_base   = '0;
    logic [127:0] m_data   = '0;
    logic [127:0] m_load   = '0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic run_cycle(input logic r, input logic s, input logic st,
                             input logic [31:0] b, input logic [127:0] d);
        bit          busy_e;
        bit          done_e;
        int          len;
        logic [31:0] addr_e;
        @(negedge clk);
        reset        = r;
        start        = s;
        is_store     = st;
        base_address = b;
        store_data   = d;
        #1;
        len    = m_store ? 5 : 6;
        busy_e = m_active && (m_k < len);
        done_e = m_active && (m_k == len);
        if (chk_en) begin
            check_eq("busy", busy, busy_e);
            check_eq("done", done, done_e);
            check_eq("load_data", load_data, m_load);
            check_eq("stall", stall, busy_e | (s & !m_active));
            if (m_fresh) begin
                check_eq("addr_rst", mem_address, 32'h0);
                check_eq("wdata_rst", mem_wdata, 32'h0);
                check_eq("we_rst", mem_we, 1'b0);
            end else if (m_active && m_k >= 1 && m_k <= 4) begin
                addr_e = m_base + 32'(4 * (m_k - 1));
                check_eq("addr", mem_address, addr_e);
                check_eq("we", mem_we, m_store & r);
                if (m_store) check_eq("wdata", mem_wdata, m_data[32*(m_k-1) +: 32]);
            end else if (m_active && !m_store && m_k == 5) begin
                addr_e = m_base + 32'd12;
                check_eq("addr_drain", mem_address, addr_e);
                check_eq("we_drain", mem_we, 1'b0);
            end else begin
                check_eq("we_idle", mem_we, 1'b0);
            end
        end
        if (!r) begin
            if (!busy_e) m_load = '0;
            m_active = 1'b0;
            m_fresh  = 1'b1;
        end else if (s && (!m_active || done_e)) begin
            m_active = 1'b1;
            m_k      = 1;
            m_store  = st;
            m_base   = b;
            m_data   = d;
            m_fresh  = 1'b0;
            accepts++;
        end else if (m_active && !done_e) begin
            m_k++;
            if (!m_store && m_k == 6) begin
                for (int i = 0; i < 4; i++) m_load[32*i +: 32] = (m_base + 32'(4 * i)) ^ 32'hA5A5A5A5;
            end
        end else begin
            m_active = 1'b0;
        end
        cyc++;
        if (cyc >= 2) chk_en = 1'b1;
    endtask

    function automatic logic [127:0] rnd_vec();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_cycle(1'b1, 1'b0, 1'b0, $urandom, rnd_vec());
    endtask

    initial begin
        logic [31:0] b;
        logic        r;
        logic        s;
        for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b0, 1'b0, 32'h0, 128'h0);
        idle(2);

        run_cycle(1'b1, 1'b1, 1'b1, 32'h100, 128'h44444444_33333333_22222222_11111111);
        idle(6);
        run_cycle(1'b1, 1'b1, 1'b0, 32'h200, rnd_vec());
        idle(7);
        run_cycle(1'b1, 1'b1, 1'b1, 32'hFFFFFFF8, rnd_vec());
        idle(6);

        // start held high, alternating store/load across accepted requests
        for (int i = 0; i < 24; i++) begin
            run_cycle(1'b1, 1'b1, (accepts % 2) == 0, $urandom, rnd_vec());
        end
        idle(7);

        // reset during store beat 2 after a completed load
        run_cycle(1'b1, 1'b1, 1'b0, 32'h300, rnd_vec());
        idle(7);
        run_cycle(1'b1, 1'b1, 1'b1, 32'h400, rnd_vec());
        idle(2);
        run_cycle(1'b0, 1'b0, 1'b0, $urandom, rnd_vec());
        idle(3);

        // requests while busy and operand changes after accept
        run_cycle(1'b1, 1'b1, 1'b1, 32'h500, rnd_vec());
        for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b1, $urandom_range(0, 1), $urandom, rnd_vec());
        idle(8);

        for (int i = 0; i < 3000; i++) begin
            b = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15))) : $urandom;
            r = ($urandom_range(0, 63) != 0);
            s = ($urandom_range(0, 2) == 0);
            run_cycle(r, s, $urandom_range(0, 1), b, rnd_vec());
        end
        idle(8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
